// File: rtl/op_issuer.sv
// Instruction front end for the FHE cpu core: buffers host operation words in a FIFO and
// issues one at a time on cpu_op, holding it until cpu_done or timeout, then drives a NO_OP gap.

package op_issuer_pkg;

  typedef enum logic [3:0] {
    NO_OP        = 4'd0,
    OP_CT_CT_ADD = 4'd1,
    OP_CT_PT_ADD = 4'd2,
    OP_CT_CT_MUL = 4'd3,
    OP_CT_PT_MUL = 4'd4,
    OP_RELIN     = 4'd5,
    OP_ROTATE    = 4'd6
  } mode_e;

  typedef struct packed {
    mode_e      mode;
    logic [7:0] idx1_a;
    logic [7:0] idx1_b;
    logic [7:0] idx2_a;
    logic [7:0] idx2_b;
    logic [7:0] out_a;
    logic [7:0] out_b;
  } operation;

  localparam int unsigned OP_W = $bits(operation);

endpackage

module op_issuer
  import op_issuer_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned GAP     = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  output logic [OP_W-1:0]          cpu_op,
  input  logic                     cpu_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_level,
  output logic                     retire_pulse,
  output logic [CNT_W-1:0]         retired_count,
  output logic                     timeout_err
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned GapW   = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StGap} state_e;

  logic [OP_W-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic              in_ready_q;
  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [OP_W-1:0]   cpu_op_q, cpu_op_d;
  logic              busy_q;
  logic              retire_q;
  logic [CNT_W-1:0]  count_q;
  logic              err_q, err_d;

  logic     push, pop, retire;
  operation head;

  assign push = in_valid && in_ready_q;
  assign head = mem_q[rd_ptr_q];

  // NO_OP is the all-zero word, so '0 is used wherever the core must see an idle op.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    cpu_op_d = cpu_op_q;
    err_d    = err_q;
    pop      = 1'b0;
    retire   = 1'b0;
    case (state_q)
      StIdle: begin
        cpu_op_d = '0;
        if (level_q != '0) begin
          pop = 1'b1;
          if (head.mode == NO_OP) begin
            retire = 1'b1;
          end else begin
            cpu_op_d = head;
            timer_d  = '0;
            state_d  = StExec;
          end
        end
      end
      StExec: begin
        // A done arriving on the final timer cycle still retires the op.
        if (cpu_done) begin
          retire   = 1'b1;
          cpu_op_d = '0;
          gap_d    = GapW'(GAP - 1);
          state_d  = StGap;
        end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
          err_d    = 1'b1;
          cpu_op_d = '0;
          gap_d    = GapW'(GAP - 1);
          state_d  = StGap;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StGap: begin
        cpu_op_d = '0;
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: begin
        cpu_op_d = '0;
        state_d  = StIdle;
      end
    endcase
  end

  assign level_d = level_q + LvlW'(push) - LvlW'(pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b0;
      state_q    <= StIdle;
      timer_q    <= '0;
      gap_q      <= '0;
      cpu_op_q   <= '0;
      busy_q     <= 1'b0;
      retire_q   <= 1'b0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q    <= level_d;
      // Space freed by a pop becomes visible one cycle later via the registered ready.
      in_ready_q <= (level_d < LvlW'(DEPTH));
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      cpu_op_q   <= cpu_op_d;
      busy_q     <= (state_d != StIdle) || (level_d != '0);
      retire_q   <= retire;
      count_q    <= count_q + CNT_W'(retire);
      err_q      <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign cpu_op        = cpu_op_q;
  assign busy          = busy_q;
  assign queue_level   = level_q;
  assign retire_pulse  = retire_q;
  assign retired_count = count_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_op_issuer.sv
// Scoreboard bench for op_issuer: issued words are captured by a monitor and compared in order
// against the words the host side pushed.

module tb_op_issuer;
  import op_issuer_pkg::*;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned GAP     = 2;
  localparam int unsigned CNT_W   = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [OP_W-1:0]        in_op = '0;
  logic [OP_W-1:0]        cpu_op;
  logic                   cpu_done = 1'b0;
  logic                   busy;
  logic [$clog2(DEPTH):0] queue_level;
  logic                   retire_pulse;
  logic [CNT_W-1:0]       retired_count;
  logic                   timeout_err;

  int checks = 0;
  int errors = 0;

  logic [OP_W-1:0] exp_q[$];
  logic [OP_W-1:0] iss_q[$];
  int              rp_cnt = 0;
  int              unstable = 0;
  int              nop_dirty = 0;
  logic [OP_W-1:0] prev_op = '0;

  op_issuer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .GAP     (GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .cpu_op        (cpu_op),
    .cpu_done      (cpu_done),
    .busy          (busy),
    .queue_level   (queue_level),
    .retire_pulse  (retire_pulse),
    .retired_count (retired_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Monitor: a new issue is a NO_OP -> non-NO_OP transition; a change while non-NO_OP is a glitch.
  always @(negedge clk) begin
    operation c, p;
    c = cpu_op;
    p = prev_op;
    if (c.mode != NO_OP) begin
      if (p.mode == NO_OP) iss_q.push_back(cpu_op);
      else if (cpu_op !== prev_op) unstable++;
    end else if (cpu_op !== '0) begin
      nop_dirty++;
    end
    if (retire_pulse === 1'b1) rp_cnt++;
    prev_op = cpu_op;
  end

  function automatic logic [OP_W-1:0] mk(input mode_e m, input int unsigned base);
    operation o;
    o.mode   = m;
    o.idx1_a = 8'(base);
    o.idx1_b = 8'(base + 1);
    o.idx2_a = 8'(base + 2);
    o.idx2_b = 8'(base + 3);
    o.out_a  = 8'(base + 4);
    o.out_b  = 8'(base + 5);
    return o;
  endfunction

  task automatic push_op(input logic [OP_W-1:0] w);
    operation o;
    bit ok;
    o = w;
    ok = 1'b0;
    in_op = w;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (ok && o.mode != NO_OP) exp_q.push_back(w);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: in_ready=%b for 200 cycles, required 1", in_ready);
    end
  endtask

  task automatic wait_exec();
    operation o;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      o = cpu_op;
      if (o.mode != NO_OP) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_issue: cpu_op=%h after 100 cycles, required a non-NO_OP word", cpu_op);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after 100 cycles, required 0", busy);
    end
  endtask

  task automatic pulse_done();
    cpu_done = 1'b1;
    @(negedge clk);
    cpu_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    cpu_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_op !== '0) begin
      errors++;
      $display("FAIL reset_cpu_op: got %h required 0 (NO_OP)", cpu_op);
    end
    checks++;
    if ({in_ready, busy, queue_level, retire_pulse, retired_count, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_status: ready=%b busy=%b level=%0d rp=%b cnt=%0d err=%b, required all 0",
               in_ready, busy, queue_level, retire_pulse, retired_count, timeout_err);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: got %b required 1", in_ready);
    end
    rp_cnt = 0;
    unstable = 0;
    nop_dirty = 0;
  endtask

  task automatic test_single();
    logic [OP_W-1:0] w, e, a;
    w = mk(OP_CT_CT_ADD, 1);
    push_op(w);
    checks++;
    if (cpu_op !== '0 || queue_level !== 4'd1) begin
      errors++;
      $display("FAIL single_no_bypass: cpu_op=%h level=%0d, required 0 and 1", cpu_op, queue_level);
    end
    @(negedge clk);
    checks++;
    if (cpu_op !== w) begin
      errors++;
      $display("FAIL single_issue: got %h required %h", cpu_op, w);
    end
    repeat (3) @(negedge clk);
    pulse_done();
    checks++;
    if (retire_pulse !== 1'b1 || retired_count !== 16'd1 || cpu_op !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_retire: rp=%b cnt=%0d op=%h busy=%b, required 1 1 0 1",
               retire_pulse, retired_count, cpu_op, busy);
    end
    @(negedge clk);
    checks++;
    if (retire_pulse !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap1: rp=%b busy=%b, required 0 1", retire_pulse, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cpu_op !== '0 || retired_count !== 16'd1) begin
      errors++;
      $display("FAIL single_idle: busy=%b op=%h cnt=%0d, required 0 0 1", busy, cpu_op, retired_count);
    end
    checks++;
    if (iss_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL single_sb_size: issued %0d required %0d", iss_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && iss_q.size() > 0) begin
      e = exp_q.pop_front();
      a = iss_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL single_sb: got %h required %h", a, e);
      end
    end
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic test_done_at_limit();
    logic [OP_W-1:0] w, e, a;
    logic [CNT_W-1:0] c0;
    c0 = retired_count;
    w = mk(OP_CT_CT_ADD, 20);
    push_op(w);
    wait_exec();
    repeat (TIMEOUT - 1) @(negedge clk);
    checks++;
    if (cpu_op !== w || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL limit_hold: op=%h err=%b, required %h 0", cpu_op, timeout_err, w);
    end
    pulse_done();
    checks++;
    if (retire_pulse !== 1'b1 || retired_count !== c0 + 16'd1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL limit_done_wins: rp=%b cnt=%0d err=%b, required 1 %0d 0",
               retire_pulse, retired_count, timeout_err, c0 + 16'd1);
    end
    wait_idle();
    while (exp_q.size() > 0 && iss_q.size() > 0) begin
      e = exp_q.pop_front();
      a = iss_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL limit_sb: got %h required %h", a, e);
      end
    end
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic test_timeout();
    logic [OP_W-1:0] wa, wb, e, a;
    logic [CNT_W-1:0] c0;
    int n, k;
    operation o;
    c0 = retired_count;
    wa = mk(OP_CT_PT_MUL, 40);
    wb = mk(OP_CT_CT_ADD, 50);
    push_op(wa);
    push_op(wb);
    wait_exec();
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err === 1'b1) break;
      n++;
    end
    checks++;
    if (n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_cycles: aborted after %0d EXEC cycles, required %0d", n, TIMEOUT);
    end
    checks++;
    if (retired_count !== c0 || retire_pulse !== 1'b0 || cpu_op !== '0) begin
      errors++;
      $display("FAIL timeout_no_retire: cnt=%0d rp=%b op=%h, required %0d 0 0",
               retired_count, retire_pulse, cpu_op, c0);
    end
    k = 0;
    for (int i = 0; i < 20; i++) begin
      o = cpu_op;
      if (o.mode != NO_OP) break;
      k++;
      @(negedge clk);
    end
    checks++;
    if (k != GAP + 1) begin
      errors++;
      $display("FAIL timeout_gap: %0d NO_OP cycles before next issue, required %0d", k, GAP + 1);
    end
    pulse_done();
    wait_idle();
    checks++;
    if (retired_count !== c0 + 16'd1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: cnt=%0d err=%b, required %0d 1",
               retired_count, timeout_err, c0 + 16'd1);
    end
    checks++;
    if (iss_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_sb_size: issued %0d required %0d", iss_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && iss_q.size() > 0) begin
      e = exp_q.pop_front();
      a = iss_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL timeout_sb: got %h required %h", a, e);
      end
    end
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic test_noop_spurious();
    logic [OP_W-1:0] w, e, a;
    logic [CNT_W-1:0] c0;
    int r0;
    c0 = retired_count;
    r0 = rp_cnt;
    w = mk(OP_CT_CT_ADD, 70);
    push_op(mk(NO_OP, 60));
    push_op(mk(NO_OP, 65));
    push_op(w);
    wait_exec();
    @(negedge clk);
    checks++;
    if (rp_cnt - r0 != 2 || retired_count !== c0 + 16'd2) begin
      errors++;
      $display("FAIL noop_retire: pulses=%0d cnt=%0d, required 2 %0d",
               rp_cnt - r0, retired_count, c0 + 16'd2);
    end
    pulse_done();
    pulse_done();
    wait_idle();
    pulse_done();
    @(negedge clk);
    checks++;
    if (rp_cnt - r0 != 3 || retired_count !== c0 + 16'd3) begin
      errors++;
      $display("FAIL spurious_done: pulses=%0d cnt=%0d, required 3 %0d",
               rp_cnt - r0, retired_count, c0 + 16'd3);
    end
    checks++;
    if (nop_dirty != 0) begin
      errors++;
      $display("FAIL noop_word: %0d cycles with non-zero NO_OP word, required 0", nop_dirty);
    end
    while (exp_q.size() > 0 && iss_q.size() > 0) begin
      e = exp_q.pop_front();
      a = iss_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL noop_sb: got %h required %h", a, e);
      end
    end
    exp_q.delete();
    iss_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [OP_W-1:0] e, a;
    logic [CNT_W-1:0] c0;
    c0 = retired_count;
    for (int i = 0; i < 9; i++) push_op(mk(OP_CT_PT_MUL, 100 + 6 * i));
    checks++;
    if (queue_level !== 4'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: level=%0d ready=%b, required 8 0", queue_level, in_ready);
    end
    fork
      push_op(mk(OP_CT_PT_MUL, 200));
      begin
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || queue_level !== 4'd8) begin
          errors++;
          $display("FAIL b2b_stall: ready=%b level=%0d, required 0 8", in_ready, queue_level);
        end
        pulse_done();
      end
    join
    for (int j = 1; j < 10; j++) begin
      wait_exec();
      repeat (2) @(negedge clk);
      pulse_done();
    end
    wait_idle();
    checks++;
    if (retired_count !== c0 + 16'd10 || queue_level !== 4'd0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count: cnt=%0d level=%0d, required %0d 0",
               retired_count, queue_level, c0 + 16'd10);
    end
    checks++;
    if (iss_q.size() != 10 || exp_q.size() != 10) begin
      errors++;
      $display("FAIL b2b_sb_size: issued %0d pushed %0d, required 10", iss_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && iss_q.size() > 0) begin
      e = exp_q.pop_front();
      a = iss_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL b2b_sb: got %h required %h", a, e);
      end
    end
    exp_q.delete();
    iss_q.delete();
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("FAIL op_stable: cpu_op changed %0d times during EXEC, required 0", unstable);
    end
  endtask

  task automatic test_reset_mid();
    logic [OP_W-1:0] w, e, a;
    for (int i = 0; i < 4; i++) push_op(mk(OP_CT_CT_MUL, 150 + 6 * i));
    checks++;
    if (queue_level !== 4'd3) begin
      errors++;
      $display("FAIL mid_level: got %0d required 3", queue_level);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (queue_level !== '0 || cpu_op !== '0 || retired_count !== '0 || timeout_err !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d op=%h cnt=%0d err=%b busy=%b ready=%b, required all 0",
               queue_level, cpu_op, retired_count, timeout_err, busy, in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    a = (iss_q.size() > 0) ? iss_q.pop_front() : '0;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL mid_first_issue: got %h required %h", a, e);
    end
    exp_q.delete();
    iss_q.delete();
    w = mk(OP_CT_PT_ADD, 220);
    push_op(w);
    wait_exec();
    checks++;
    if (cpu_op !== w) begin
      errors++;
      $display("FAIL mid_fresh_issue: got %h required %h", cpu_op, w);
    end
    pulse_done();
    checks++;
    if (retired_count !== 16'd1 || retire_pulse !== 1'b1) begin
      errors++;
      $display("FAIL mid_fresh_retire: cnt=%0d rp=%b, required 1 1", retired_count, retire_pulse);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_done_at_limit();
    test_timeout();
    test_noop_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
